// File: rtl/dequant_line_sequencer.sv
// Line sequencer for the parallel dequantizer: splits a quantized line into beats of LANES words,
// drives the external mantissa/exponent formers and packs their results into a float line.
module dequant_line_sequencer #(
  parameter int L2WIDTH   = 512,
  parameter int WWIDTH    = 32,
  parameter int EXPLENGTH = 8,
  parameter int LANES     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [L2WIDTH-1:0]           in_data,
  input  logic [EXPLENGTH-1:0]         in_step_exp,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [L2WIDTH-1:0]           out_data,
  output logic                         busy,
  output logic [LANES*EXPLENGTH-1:0]   former_step_exp,
  output logic [LANES*WWIDTH-1:0]      former_mag,
  output logic [LANES*6-1:0]           former_loc,
  input  logic [LANES*7-1:0]           former_exp,
  input  logic [LANES*24-1:0]          former_man
);

  localparam int WORDS     = L2WIDTH / WWIDTH;
  localparam int BEATS     = WORDS / LANES;
  localparam int BEAT_BITS = LANES * WWIDTH;
  localparam int BW        = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic [L2WIDTH-1:0]     line_q, line_d;
  logic [EXPLENGTH-1:0]   step_q, step_d;
  logic [L2WIDTH-1:0]     out_q, out_d;

  logic                   run;
  logic [BEAT_BITS-1:0]   beat_slice;
  logic [BEAT_BITS-1:0]   beat_result;

  // Position of the highest set bit plus one; zero means no bit set.
  function automatic logic [5:0] find_loc(input logic [WWIDTH-1:0] m);
    logic [5:0] r;
    r = '0;
    for (int i = 0; i < WWIDTH; i++) begin
      if (m[i]) r = 6'(i + 1);
    end
    return r;
  endfunction

  assign beat_slice = line_q[int'(beat_q) * BEAT_BITS +: BEAT_BITS];

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [WWIDTH-1:0] w;
      logic              sgn;
      logic [WWIDTH-1:0] mag;
      logic [5:0]        loc;
      logic              unused_man_lsb;

      assign w   = beat_slice[gi*WWIDTH +: WWIDTH];
      assign sgn = w[WWIDTH-1];
      // Two's-complement negate keeps -2^31 as 0x8000_0000, which is the wanted magnitude.
      assign mag = sgn ? (~w + 1'b1) : w;
      assign loc = find_loc(mag);

      assign former_mag[gi*WWIDTH +: WWIDTH]            = run ? mag : '0;
      assign former_loc[gi*6 +: 6]                      = run ? loc : '0;
      assign former_step_exp[gi*EXPLENGTH +: EXPLENGTH] = run ? step_q : '0;

      // A zero word must pack to +0, never to the signed-zero pattern.
      assign beat_result[gi*WWIDTH +: WWIDTH] = (loc == 6'd0) ? '0 :
          {sgn, 1'b0, former_exp[gi*7 +: 7], former_man[gi*24+1 +: 23]};
      assign unused_man_lsb = former_man[gi*24];
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    line_d    = line_q;
    step_d    = step_q;
    out_d     = out_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    run       = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          line_d  = in_data;
          step_d  = in_step_exp;
          beat_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        run  = 1'b1;
        out_d[int'(beat_q) * BEAT_BITS +: BEAT_BITS] = beat_result;
        beat_d = beat_q + 1'b1;
        if (beat_q == BW'(BEATS - 1)) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      line_q  <= '0;
      step_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      step_q  <= step_d;
      out_q   <= out_d;
    end
  end

  assign out_data = out_q;

endmodule
